// File: rtl/graph_pkg.sv
// graph_pkg: shared codes and constants for the graph search job controller
package graph_pkg;

    localparam int NUM_POSE = 66;
    localparam int NUM_EDGE = 1034;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 16;
    localparam int CHAIN_W  = 110;

    typedef enum logic [2:0] {
        ES_FWD_INIT = 3'd0,
        ES_FWD_WORK = 3'd1,
        ES_BWD_INIT = 3'd2,
        ES_BWD_WORK = 3'd3,
        ES_FAIL     = 3'd4,
        ES_FINISH   = 3'd5
    } eng_state_e;

    localparam logic [2:0] CTRL_IDLE = 3'b000;
    localparam logic [2:0] CTRL_FWD  = 3'b010;
    localparam logic [2:0] CTRL_BWD  = 3'b100;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_NOPATH  = 3'd1,
        ST_TIMEOUT = 3'd2,
        ST_BADPOSE = 3'd3,
        ST_TRIVIAL = 3'd4
    } res_status_e;

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD, S_ERST, S_FWD_GO, S_FWD_RUN, S_BWD_GO, S_BWD_RUN, S_DONE
    } fsm_e;

endpackage

// File: rtl/graph_ram_arb.sv
// graph_ram_arb: edge-table port mux, host owns it when idle, engine otherwise
module graph_ram_arb import graph_pkg::*; (
    input  logic              idle,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic [ADDR_W-1:0] eng_ram_addr,
    output logic              host_wr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata
);

    // select the port owner from the controller's idle flag
    always_comb begin
        host_wr_ready = idle;
        ram_addr      = idle ? host_wr_addr : eng_ram_addr;
        ram_we        = idle & host_wr_en;
        ram_wdata     = idle ? host_wr_data : '0;
    end

endmodule

// File: rtl/graph_search_seq.sv
// graph_search_seq: job-level sequencer driving the graph search engine phases
module graph_search_seq #(
    parameter int NUM_POSE    = graph_pkg::NUM_POSE,
    parameter int NUM_EDGE    = graph_pkg::NUM_EDGE,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int RST_CYC     = 2
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_start,
    input  logic [7:0]          req_end,
    input  logic                mask_valid,
    input  logic [NUM_EDGE-1:0] mask_in,
    output logic                eng_rst_n,
    output logic [2:0]          eng_control,
    input  logic [2:0]          eng_state,
    output logic [7:0]          eng_start,
    output logic [7:0]          eng_end,
    output logic [NUM_EDGE-1:0] eng_mask,
    input  logic [10:0]         eng_ram_addr,
    input  logic [109:0]        eng_sel_edge,
    input  logic                host_wr_en,
    input  logic [10:0]         host_wr_addr,
    input  logic [15:0]         host_wr_data,
    output logic                host_wr_ready,
    output logic [10:0]         ram_addr,
    output logic                ram_we,
    output logic [15:0]         ram_wdata,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [2:0]          res_status,
    output logic [109:0]        res_edges
);

    import graph_pkg::*;

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYC - 1);
    localparam logic [7:0]    POSE_LIM = 8'(NUM_POSE);

    fsm_e                state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                eng_rst_n_q, eng_rst_n_d;
    logic [2:0]          eng_control_q, eng_control_d;
    logic [7:0]          eng_start_q, eng_start_d;
    logic [7:0]          eng_end_q, eng_end_d;
    logic [NUM_EDGE-1:0] eng_mask_q, eng_mask_d;
    logic                res_valid_q, res_valid_d;
    res_status_e         res_status_q, res_status_d;
    logic [109:0]        res_edges_q, res_edges_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                in_eng;

    // next-state logic: phase sequencing, timeout override, then DONE-entry side effects
    always_comb begin
        state_d       = state_q;
        eng_rst_n_d   = eng_rst_n_q;
        eng_control_d = eng_control_q;
        eng_start_d   = eng_start_q;
        eng_end_d     = eng_end_q;
        eng_mask_d    = eng_mask_q;
        res_valid_d   = res_valid_q;
        res_status_d  = res_status_q;
        res_edges_d   = res_edges_q;
        timer_d       = timer_q;
        in_eng        = state_q inside {S_ERST, S_FWD_GO, S_FWD_RUN, S_BWD_GO, S_BWD_RUN};
        case (state_q)
            S_IDLE: if (req_valid) begin
                eng_start_d = req_start;
                eng_end_d   = req_end;
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                if (eng_start_q >= POSE_LIM || eng_end_q >= POSE_LIM) begin
                    state_d      = S_DONE;
                    res_status_d = ST_BADPOSE;
                end else if (eng_start_q == eng_end_q) begin
                    state_d      = S_DONE;
                    res_status_d = ST_TRIVIAL;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: if (mask_valid) begin
                eng_mask_d = mask_in;
                timer_d    = '0;
                state_d    = S_ERST;
            end
            S_ERST: if (timer_q == RST_LAST) begin
                eng_rst_n_d   = 1'b1;
                eng_control_d = CTRL_FWD;
                state_d       = S_FWD_GO;
            end
            S_FWD_GO: if (eng_state != ES_FWD_INIT) begin
                eng_control_d = CTRL_IDLE;
                state_d       = S_FWD_RUN;
            end
            S_FWD_RUN: begin
                if (eng_state == ES_BWD_INIT) begin
                    eng_control_d = CTRL_BWD;
                    state_d       = S_BWD_GO;
                end else if (eng_state != ES_FWD_WORK) begin
                    state_d      = S_DONE;
                    res_status_d = ST_NOPATH;
                end
            end
            S_BWD_GO: if (eng_state != ES_BWD_INIT) begin
                eng_control_d = CTRL_IDLE;
                state_d       = S_BWD_RUN;
            end
            S_BWD_RUN: begin
                if (eng_state == ES_FINISH) begin
                    res_edges_d  = eng_sel_edge;
                    res_status_d = ST_OK;
                    state_d      = S_DONE;
                end else if (eng_state != ES_BWD_WORK) begin
                    state_d      = S_DONE;
                    res_status_d = ST_NOPATH;
                end
            end
            S_DONE: if (res_ready) begin
                res_valid_d = 1'b0;
                timer_d     = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (in_eng) begin
            if (timer_q == TO_LAST) begin
                state_d      = S_DONE;
                res_status_d = ST_TIMEOUT;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            res_valid_d   = 1'b1;
            eng_control_d = CTRL_IDLE;
            eng_rst_n_d   = 1'b0;
            if (res_status_d != ST_OK) res_edges_d = '0;
        end
        req_ready_d = (state_d == S_IDLE);
    end

    // state and registered outputs, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            eng_rst_n_q   <= 1'b0;
            eng_control_q <= CTRL_IDLE;
            eng_start_q   <= '0;
            eng_end_q     <= '0;
            eng_mask_q    <= '0;
            res_valid_q   <= 1'b0;
            res_status_q  <= ST_OK;
            res_edges_q   <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            eng_rst_n_q   <= eng_rst_n_d;
            eng_control_q <= eng_control_d;
            eng_start_q   <= eng_start_d;
            eng_end_q     <= eng_end_d;
            eng_mask_q    <= eng_mask_d;
            res_valid_q   <= res_valid_d;
            res_status_q  <= res_status_d;
            res_edges_q   <= res_edges_d;
            timer_q       <= timer_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign eng_rst_n   = eng_rst_n_q;
    assign eng_control = eng_control_q;
    assign eng_start   = eng_start_q;
    assign eng_end     = eng_end_q;
    assign eng_mask    = eng_mask_q;
    assign res_valid   = res_valid_q;
    assign res_status  = res_status_q;
    assign res_edges   = res_edges_q;

    graph_ram_arb u_arb (
        .idle          (state_q == S_IDLE),
        .host_wr_en    (host_wr_en),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .eng_ram_addr  (eng_ram_addr),
        .host_wr_ready (host_wr_ready),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata)
    );

endmodule

// File: tb/tb_graph_search_seq.sv
// tb_graph_search_seq: directed self-checking bench for the graph search sequencer
module tb_graph_search_seq;

    logic          CLK, RST_n;
    logic          req_valid, req_ready;
    logic [7:0]    req_start, req_end;
    logic          mask_valid;
    logic [1033:0] mask_in, mask_pat;
    logic          eng_rst_n;
    logic [2:0]    eng_control, eng_state;
    logic [7:0]    eng_start, eng_end;
    logic [1033:0] eng_mask;
    logic [10:0]   eng_ram_addr;
    logic [109:0]  eng_sel_edge;
    logic          host_wr_en, host_wr_ready;
    logic [10:0]   host_wr_addr, ram_addr;
    logic [15:0]   host_wr_data, ram_wdata;
    logic          ram_we, res_valid, res_ready;
    logic [2:0]    res_status;
    logic [109:0]  res_edges;

    int errors = 0;
    int checks = 0;

    graph_search_seq #(.TIMEOUT_CYC(100), .RST_CYC(2)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_start(req_start), .req_end(req_end),
        .mask_valid(mask_valid), .mask_in(mask_in),
        .eng_rst_n(eng_rst_n), .eng_control(eng_control), .eng_state(eng_state),
        .eng_start(eng_start), .eng_end(eng_end), .eng_mask(eng_mask),
        .eng_ram_addr(eng_ram_addr), .eng_sel_edge(eng_sel_edge),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_wr_ready(host_wr_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status), .res_edges(res_edges)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ctrl(input logic [2:0] v, input string tag);
        int n = 0;
        while (eng_control !== v && n < 50) begin
            tick();
            n++;
        end
        chk(tag, eng_control, v);
    endtask

    task automatic request(input logic [7:0] s, input logic [7:0] e);
        req_valid = 1'b1;
        req_start = s;
        req_end   = e;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic release_result;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        RST_n = 1'b0; req_valid = 1'b0; req_start = '0; req_end = '0;
        mask_valid = 1'b0; mask_in = '0; eng_state = 3'd0; eng_ram_addr = '0;
        eng_sel_edge = '0; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        res_ready = 1'b0;
        mask_pat = '0;
        mask_pat[1033] = 1'b1;
        mask_pat[15:0] = 16'hBEEF;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_eng_rst_n", eng_rst_n, 0);
        chk("rst_eng_control", eng_control, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_status", res_status, 0);
        chk("rst_res_edges", res_edges, 0);
        chk("rst_eng_mask_zero", eng_mask === '0, 1);
        RST_n = 1'b1;
        tick();

        // full OK job with engine walking 0->1->2->3->5
        mask_valid = 1'b1;
        mask_in = mask_pat;
        request(8'd3, 8'd40);
        chk("ok_req_ready_low", req_ready, 0);
        chk("ok_eng_start", eng_start, 3);
        chk("ok_eng_end", eng_end, 40);
        tick(); tick(); tick();
        chk("ok_ctrl_before_latency", eng_control, 0);
        chk("ok_rst_n_held", eng_rst_n, 0);
        chk("ok_eng_mask", eng_mask === mask_pat, 1);
        tick();
        chk("ok_ctrl_fwd_latency", eng_control, 3'b010);
        chk("ok_rst_n_released", eng_rst_n, 1);
        eng_state = 3'd1;
        tick();
        chk("ok_ctrl_fwd_clear", eng_control, 0);
        host_wr_en = 1'b1; host_wr_addr = 11'd5; host_wr_data = 16'h0310; eng_ram_addr = 11'd7;
        #1;
        chk("busy_host_wr_ready", host_wr_ready, 0);
        chk("busy_ram_we", ram_we, 0);
        chk("busy_ram_addr", ram_addr, 7);
        host_wr_en = 1'b0;
        eng_state = 3'd2;
        tick();
        chk("ok_ctrl_bwd", eng_control, 3'b100);
        eng_state = 3'd3;
        tick();
        chk("ok_ctrl_bwd_clear", eng_control, 0);
        eng_sel_edge = 110'h2A5;
        eng_state = 3'd5;
        tick();
        eng_state = 3'd0;
        eng_sel_edge = 110'h111;
        chk("ok_res_valid", res_valid, 1);
        chk("ok_res_status", res_status, 0);
        chk("ok_res_edges", res_edges, 110'h2A5);
        chk("ok_done_rst_n", eng_rst_n, 0);
        release_result();
        chk("ok_back_idle_ready", req_ready, 1);
        chk("ok_res_valid_clear", res_valid, 0);

        // bad pose reports within three cycles, engine untouched
        request(8'd70, 8'd5);
        tick();
        chk("bad_res_valid", res_valid, 1);
        chk("bad_status", res_status, 3);
        chk("bad_rst_n", eng_rst_n, 0);
        chk("bad_ctrl", eng_control, 0);
        release_result();

        // trivial and bad-over-trivial
        request(8'd12, 8'd12);
        tick();
        chk("triv_status", res_status, 4);
        chk("triv_edges", res_edges, 0);
        release_result();
        request(8'd80, 8'd80);
        tick();
        chk("badtriv_status", res_status, 3);
        release_result();

        // engine fails in forward phase, result held while res_ready low
        request(8'd1, 8'd2);
        wait_ctrl(3'b010, "np_wait_fwd");
        eng_state = 3'd1;
        tick();
        eng_state = 3'd4;
        tick();
        chk("np_status", res_status, 1);
        req_valid = 1'b1; req_start = 8'd7; req_end = 8'd9;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("np_hold_valid", res_valid, 1);
            chk("np_hold_status", res_status, 1);
            chk("np_hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        eng_state = 3'd0;
        release_result();

        // timeout: engine stuck in forward work, DONE 100 cycles after ERST entry
        request(8'd4, 8'd9);
        tick(); tick();
        chk("to_in_erst", eng_rst_n, 0);
        eng_state = 3'd1;
        for (int i = 0; i < 99; i++) tick();
        chk("to_not_yet", res_valid, 0);
        tick();
        chk("to_res_valid", res_valid, 1);
        chk("to_status", res_status, 2);
        chk("to_ctrl", eng_control, 0);
        chk("to_rst_n", eng_rst_n, 0);
        eng_state = 3'd0;
        release_result();

        // host write while idle
        host_wr_en = 1'b1; host_wr_addr = 11'd5; host_wr_data = 16'h0310; eng_ram_addr = 11'd9;
        #1;
        chk("idle_host_wr_ready", host_wr_ready, 1);
        chk("idle_ram_we", ram_we, 1);
        chk("idle_ram_addr", ram_addr, 5);
        chk("idle_ram_wdata", ram_wdata, 16'h0310);
        host_wr_en = 1'b0;

        // reset during backward run discards the job
        request(8'd10, 8'd20);
        wait_ctrl(3'b010, "rs_wait_fwd");
        eng_state = 3'd1; tick();
        eng_state = 3'd2; tick();
        eng_state = 3'd3; tick();
        RST_n = 1'b0;
        tick();
        chk("rs_req_ready", req_ready, 1);
        chk("rs_res_valid", res_valid, 0);
        chk("rs_rst_n", eng_rst_n, 0);
        chk("rs_ctrl", eng_control, 0);
        chk("rs_eng_start", eng_start, 0);
        RST_n = 1'b1;
        eng_state = 3'd0;
        tick();

        // unexpected code 0 during backward run is a no-path
        request(8'd1, 8'd5);
        wait_ctrl(3'b010, "ux_wait_fwd");
        eng_state = 3'd1; tick();
        eng_state = 3'd2; tick();
        eng_state = 3'd3; tick();
        eng_state = 3'd0; tick();
        chk("ux_res_valid", res_valid, 1);
        chk("ux_status", res_status, 1);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
